// File: rtl/multi_byte_add_seq.sv
// multi_byte_add_seq: streams LSB-first operand byte pairs through an external
// 8-bit ripple-carry adder. The adder's carry-out is fed back as the next
// carry-in, so one 8-bit adder computes N-byte (1..2^MAXLEN_W) sums or
// differences. Each result byte lands in a one-deep valid/ready output stage.
module multi_byte_add_seq #(
  parameter int MAXLEN_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MAXLEN_W-1:0] len,
  input  logic                sub_mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_add,
  input  logic [7:0]          in_aug,
  output logic [7:0]          fa_add,
  output logic [7:0]          fa_aug,
  output logic                fa_prec,
  input  logic [7:0]          fa_sum,
  input  logic                fa_proc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_sum,
  output logic                out_last,
  output logic                out_carry,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  carry_reg, carry_next;
  logic [MAXLEN_W-1:0]   count_reg, count_next;
  logic [MAXLEN_W-1:0]   len_reg, len_next;
  logic                  sub_reg, sub_next;
  logic                  out_valid_reg, out_valid_next;
  logic [7:0]            out_sum_reg, out_sum_next;
  logic                  out_last_reg, out_last_next;
  logic                  out_carry_reg, out_carry_next;
  logic                  done_reg, done_next;

  logic                  accept;
  logic                  last_byte;

  // Adder drive: subtraction is add of the one's complement of the augend,
  // with the +1 supplied as the initial carry-in loaded at start.
  assign fa_add  = in_add;
  assign fa_prec = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_aug_inv
      assign fa_aug[gi] = in_aug[gi] ^ sub_reg;
    end
  endgenerate

  // Input can be taken only while running and the output stage is free or
  // being drained in this same cycle.
  assign in_ready  = (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_byte = (count_reg == len_reg);

  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_last  = out_last_reg;
  assign out_carry = out_carry_reg;
  assign done      = done_reg;

  // Next-state and datapath update decisions; every register holds by default.
  always_comb begin
    state_next     = state_reg;
    carry_next     = carry_reg;
    count_next     = count_reg;
    len_next       = len_reg;
    sub_next       = sub_reg;
    out_valid_next = out_valid_reg;
    out_sum_next   = out_sum_reg;
    out_last_next  = out_last_reg;
    out_carry_next = out_carry_reg;
    done_next      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          len_next   = len;
          sub_next   = sub_mode;
          carry_next = sub_mode;
          count_next = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        if (accept) begin
          out_sum_next   = fa_sum;
          out_valid_next = 1'b1;
          carry_next     = fa_proc;
          // Compare happens on the pre-increment count, so the wrap after
          // the final byte of a maximum-length operation is harmless.
          count_next     = count_reg + 1'b1;
          if (last_byte) begin
            out_last_next  = 1'b1;
            out_carry_next = fa_proc;
            state_next     = FLUSH;
          end
        end else if (out_ready) begin
          out_valid_next = 1'b0;
        end
      end

      FLUSH: begin
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
          out_carry_next = 1'b0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and output-stage registers; reset discards any pending byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg     <= 1'b0;
      count_reg     <= '0;
      len_reg       <= '0;
      sub_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= 8'h00;
      out_last_reg  <= 1'b0;
      out_carry_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      carry_reg     <= carry_next;
      count_reg     <= count_next;
      len_reg       <= len_next;
      sub_reg       <= sub_next;
      out_valid_reg <= out_valid_next;
      out_sum_reg   <= out_sum_next;
      out_last_reg  <= out_last_next;
      out_carry_reg <= out_carry_next;
      done_reg      <= done_next;
    end
  end

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Testbench for multi_byte_add_seq: table-driven multi-byte add/subtract
// vectors plus hand-written backpressure, abort and ignored-start sequences.
// The external 8-bit adder is modelled combinationally here.
module tb_multi_byte_add_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       sub_mode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_add;
  logic [7:0] in_aug;
  logic [7:0] fa_add;
  logic [7:0] fa_aug;
  logic       fa_prec;
  logic [7:0] fa_sum;
  logic       fa_proc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_carry;
  logic       busy;
  logic       done;

  int tests_run;
  int tests_failed;

  multi_byte_add_seq #(.MAXLEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .sub_mode  (sub_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_add    (in_add),
    .in_aug    (in_aug),
    .fa_add    (fa_add),
    .fa_aug    (fa_aug),
    .fa_prec   (fa_prec),
    .fa_sum    (fa_sum),
    .fa_proc   (fa_proc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .busy      (busy),
    .done      (done)
  );

  // External ripple-carry adder model.
  logic [8:0] fa_res;
  assign fa_res  = {1'b0, fa_add} + {1'b0, fa_aug} + {8'h00, fa_prec};
  assign fa_sum  = fa_res[7:0];
  assign fa_proc = fa_res[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   len;
    logic         sub;
    logic [127:0] a;      // in_add bytes, byte k at [8k +: 8]
    logic [127:0] b;      // in_aug bytes
    logic [127:0] s;      // expected result bytes
    logic         carry;  // expected final carry
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l, input logic s);
    start    = 1'b1;
    len      = l;
    sub_mode = s;
    tick();
    start    = 1'b0;
    len      = 4'hA;
    sub_mode = ~s;
    check("busy_after_start", busy, 1);
  endtask

  // Run one table vector with out_ready held high; one byte per cycle.
  task automatic run_vec(input int idx, input vec_t v);
    do_start(v.len, v.sub);
    for (int k = 0; k <= int'(v.len); k++) begin
      in_valid = 1'b1;
      in_add   = v.a[8*k +: 8];
      in_aug   = v.b[8*k +: 8];
      #1;
      check("in_ready_run", in_ready, 1);
      tick();
      check("out_valid", out_valid, 1);
      check("out_sum", out_sum, v.s[8*k +: 8]);
      check("out_last", out_last, (k == int'(v.len)) ? 1 : 0);
      if (k == int'(v.len)) check("out_carry", out_carry, v.carry);
      $display("[TB] vec %0d byte %0d: add=%02h aug=%02h sum=%02h last=%0b carry=%0b",
               idx, k, v.a[8*k +: 8], v.b[8*k +: 8], out_sum, out_last, out_carry);
    end
    in_valid = 1'b0;
    check("in_ready_flush", in_ready, 0);
    tick();
    check("done_pulse", done, 1);
    check("busy_idle", busy, 0);
    check("out_valid_clear", out_valid, 0);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 4'h0;
    sub_mode  = 1'b0;
    in_valid  = 1'b0;
    in_add    = 8'h00;
    in_aug    = 8'h00;
    out_ready = 1'b1;

    // Hand-computed vectors.
    vecs[0] = '{len: 4'd0,  sub: 1'b0, a: 128'h12,       b: 128'h34,       s: 128'h46,       carry: 1'b0};
    vecs[1] = '{len: 4'd1,  sub: 1'b0, a: 128'h01FF,     b: 128'h0001,     s: 128'h0200,     carry: 1'b0};
    vecs[2] = '{len: 4'd1,  sub: 1'b1, a: 128'h0100,     b: 128'h0001,     s: 128'h00FF,     carry: 1'b1};
    vecs[3] = '{len: 4'd15, sub: 1'b0, a: {16{8'hFF}},   b: 128'h01,       s: 128'h0,        carry: 1'b1};
    vecs[4] = '{len: 4'd2,  sub: 1'b1, a: 128'h000005,   b: 128'h000007,   s: 128'hFFFFFE,   carry: 1'b0};
    vecs[5] = '{len: 4'd3,  sub: 1'b0, a: 128'h12345678, b: 128'h87654321, s: 128'h99999999, carry: 1'b0};
    vecs[6] = '{len: 4'd0,  sub: 1'b0, a: 128'h80,       b: 128'h80,       s: 128'h00,       carry: 1'b1};

    // Reset state.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_fa_prec", fa_prec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: 0x04030201 + 0x10101010 = 0x14131211.
    do_start(4'd3, 1'b0);
    in_valid = 1'b1; in_add = 8'h01; in_aug = 8'h10;
    tick();
    check("bp_byte0", out_sum, 8'h11);
    out_ready = 1'b0;
    in_add = 8'h02; in_aug = 8'h10;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready_low", in_ready, 0);
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", out_sum, 8'h11);
      $display("[TB] stall cycle %0d: in_ready=%0b out_sum=%02h", c, in_ready, out_sum);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_back", in_ready, 1);
    tick();
    check("bp_byte1", out_sum, 8'h12);
    in_add = 8'h03;
    tick();
    check("bp_byte2", out_sum, 8'h13);
    check("bp_byte2_last", out_last, 0);
    in_add = 8'h04;
    tick();
    check("bp_byte3", out_sum, 8'h14);
    check("bp_byte3_last", out_last, 1);
    check("bp_carry", out_carry, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("flush_hold_valid", out_valid, 1);
    check("flush_hold_last", out_last, 1);
    check("flush_no_done", done, 0);
    out_ready = 1'b1;
    tick();
    check("bp_done", done, 1);
    check("bp_idle", busy, 0);
    $display("[TB] backpressure sequence complete");
    tick();

    // Ignored start: 0x0301 + 0x0402 = 0x0703; start pulsed mid-run.
    do_start(4'd1, 1'b0);
    in_valid = 1'b1; in_add = 8'h01; in_aug = 8'h02;
    tick();
    check("ign_byte0", out_sum, 8'h03);
    start = 1'b1; len = 4'd0; sub_mode = 1'b1;
    in_add = 8'h03; in_aug = 8'h04;
    tick();
    start = 1'b0;
    check("ign_byte1", out_sum, 8'h07);
    check("ign_last", out_last, 1);
    check("ign_carry", out_carry, 0);
    in_valid = 1'b0;
    tick();
    check("ign_done", done, 1);
    $display("[TB] ignored-start sequence: sum=07 last=1");
    tick();

    // Abort: reset asserted while byte 2 (third byte) is being captured.
    do_start(4'd3, 1'b0);
    in_valid = 1'b1; in_add = 8'h11; in_aug = 8'h22;
    tick();
    tick();
    check("abort_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sum", out_sum, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_stay_idle", busy, 0);
    $display("[TB] abort sequence: busy=%0b out_valid=%0b", busy, out_valid);

    // Operation after abort must start clean.
    run_vec(7, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
